uio_bus_arbiter: RTL
====================

Name: uio_bus_arbiter

Overview:
- Round-robin arbiter that shares the single 8-bit bidirectional uio pad bank (uio_in/uio_out/uio_oe) between NUM_REQ internal requesters of the top-level tt_um design.
- Sequences pad direction with a mandatory turnaround gap and enforces a hold-time limit per grant.
- Sits between the user logic and the uio pins inside the top module.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TURNAROUND, 1, idle cycles with uio_oe=0 between grant decision and ownership (>=1).
- HOLD_MAX, 15, maximum consecutive ownership cycles per grant (1..255).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- ena  input  1  design enable; low blocks new grants and forces release
- req  input  NUM_REQ  per-requester bus request, level, held until done
- dir  input  NUM_REQ  per-requester direction: 1=drive pins, 0=sample pins
- wdata  input  8*NUM_REQ  write data, requester i on bits [8i+7:8i]
- gnt  output  NUM_REQ  one-hot grant, registered
- uio_out  output  8  pad output data, registered
- uio_oe  output  8  pad enable, registered, 8'hFF or 8'h00 only
- uio_in  input  8  pad input data
- rdata  output  8  registered sample of uio_in for the read owner
- rdata_valid  output  1  high each cycle rdata is updated
- timeout  output  1  one-cycle pulse when a grant is revoked by HOLD_MAX

Behaviour:
- Reset (synchronous, rst=1 at an edge): state IDLE, rr pointer=0, hold_cnt=0, turn_cnt=0; gnt=0, uio_out=0, uio_oe=0, rdata=0, rdata_valid=0, timeout=0. Reset mid-ownership drops gnt and uio_oe at that same edge.
- States: IDLE, TURN, OWN.
- IDLE: if ena=1 and req!=0, select the first set req bit searching from index ptr upward, wrapping modulo NUM_REQ; latch winner; turn_cnt=0; go TURN. uio_oe=0, gnt=0.
- TURN: uio_oe=0, gnt=0; turn_cnt increments; after TURNAROUND cycles, go OWN, set gnt[winner]=1, hold_cnt=0. Winner's req dropping during TURN -> return to IDLE, ptr=winner+1. ena=0 -> IDLE, ptr unchanged.
- Latency: req sampled at edge k in IDLE -> gnt high after edge k+TURNAROUND (k+1 by default).
- OWN, each edge:
  - dir[winner]=1: uio_oe<=8'hFF, uio_out<=wdata[winner] (one-cycle pad latency), rdata_valid<=0.
  - dir[winner]=0: uio_oe<=0, rdata<=uio_in, rdata_valid<=1.
  - dir change mid-grant takes effect at the next edge without turnaround.
  - hold_cnt increments.
- Release from OWN to IDLE; gnt, uio_oe and rdata_valid clear at that edge; uio_out holds its last value:
  - req[winner]=0: normal release.
  - hold_cnt==HOLD_MAX-1: timeout pulses for one cycle; maximum ownership is exactly HOLD_MAX cycles.
  - ena=0: no timeout pulse.
  - In all three cases ptr<=winner+1 mod NUM_REQ.
- Minimum one IDLE cycle between grants; uio_oe is never high in IDLE or TURN, so there is no back-to-back drive.
- Timed-out requester still asserting req is re-arbitrated with lowest priority under the advanced pointer.
- Requests from non-winners are ignored until IDLE; simultaneous requests resolve purely by pointer order.

Test Plan:
- Reset: drive rst=1 with random req/wdata -> gnt=0, uio_oe=0x00, uio_out=0x00, timeout=0 on every cycle while reset held.
- Single write: req=0001, dir=0001, wdata[7:0]=0xA5 from edge 0 -> gnt=0001 after edge 1, uio_oe=0xFF and uio_out=0xA5 after edge 2; drop req -> gnt=0, uio_oe=0 next edge.
- Round robin: req=1111 held continuously with HOLD_MAX=3 -> grant order 0,1,2,3,0; each gnt lasts 3 cycles followed by a timeout pulse; a >=2 cycle gap with uio_oe=0 between grants.
- Read path: req=0100, dir=0000, uio_in stepping 0x10,0x11,0x12 -> gnt=0100, uio_oe=0x00, rdata follows uio_in one cycle later with rdata_valid=1.
- ena drop: during OWN by requester 1, ena=0 for one edge -> gnt=0, uio_oe=0 next edge, timeout stays 0, no new grant while ena=0.
- Reset mid-operation: rst=1 during OWN with uio_oe=0xFF -> uio_oe=0, gnt=0 at that edge; after release with req=0011, requester 0 is granted first (ptr=0).

Source files
------------

// File: rtl/uio_bus_arbiter.sv
// Round-robin arbiter sharing the 8-bit bidirectional uio pad bank between NUM_REQ requesters.
// Grants pass through a turnaround gap with pads released, and ownership is capped at HOLD_MAX cycles.
module uio_bus_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned TURNAROUND = 1,
  parameter int unsigned HOLD_MAX   = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   dir,
  input  logic [8*NUM_REQ-1:0] wdata,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [7:0]           uio_out,
  output logic [7:0]           uio_oe,
  input  logic [7:0]           uio_in,
  output logic [7:0]           rdata,
  output logic                 rdata_valid,
  output logic                 timeout
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned TW = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_TURN,
    S_OWN
  } state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        win_q, win_d;
  logic [TW-1:0]        turn_cnt_q, turn_cnt_d;
  logic [7:0]           hold_cnt_q, hold_cnt_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [7:0]           oe_q, oe_d;
  logic [7:0]           out_q, out_d;
  logic [7:0]           rdata_q, rdata_d;
  logic                 valid_q, valid_d;
  logic                 timeout_q, timeout_d;

  logic [IW-1:0]        cand;
  logic [IW-1:0]        pick_idx;
  logic                 pick_found;
  logic [7:0]           wsel;
  logic                 req_win;
  logic                 dir_win;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (32'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  // First requester at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    cand       = '0;
    pick_idx   = ptr_q;
    pick_found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IW'((32'(ptr_q) + k) % NUM_REQ);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    wsel = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (32'(win_q) == k) begin
        wsel = wdata[8*k +: 8];
      end
    end
  end

  assign req_win = req[win_q];
  assign dir_win = dir[win_q];

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    turn_cnt_d = turn_cnt_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = '0;
    oe_d       = '0;
    out_d      = out_q;
    rdata_d    = rdata_q;
    valid_d    = 1'b0;
    timeout_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (ena && (|req)) begin
          win_d      = pick_idx;
          turn_cnt_d = '0;
          state_d    = S_TURN;
        end
      end

      S_TURN: begin
        if (!ena) begin
          state_d = S_IDLE;
        end else if (!req_win) begin
          state_d = S_IDLE;
          ptr_d   = next_idx(win_q);
        end else if (turn_cnt_q == TW'(TURNAROUND - 1)) begin
          state_d    = S_OWN;
          gnt_d      = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_q;
          hold_cnt_d = '0;
        end else begin
          turn_cnt_d = turn_cnt_q + 1'b1;
        end
      end

      S_OWN: begin
        // A release edge takes no data action; the pads go idle immediately.
        if (!ena || !req_win || (hold_cnt_q == 8'(HOLD_MAX - 1))) begin
          state_d   = S_IDLE;
          ptr_d     = next_idx(win_q);
          timeout_d = ena && req_win;
        end else begin
          gnt_d      = gnt_q;
          hold_cnt_d = hold_cnt_q + 1'b1;
          if (dir_win) begin
            oe_d  = '1;
            out_d = wsel;
          end else begin
            rdata_d = uio_in;
            valid_d = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      turn_cnt_q <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      oe_q       <= '0;
      out_q      <= '0;
      rdata_q    <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      turn_cnt_q <= turn_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      oe_q       <= oe_d;
      out_q      <= out_d;
      rdata_q    <= rdata_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
    end
  end

  assign gnt         = gnt_q;
  assign uio_oe      = oe_q;
  assign uio_out     = out_q;
  assign rdata       = rdata_q;
  assign rdata_valid = valid_q;
  assign timeout     = timeout_q;

endmodule
